// File: rtl/mult_bus_pkg.sv
// Shared state encoding and peripheral register map for the multiplier bus master.
// Timeout polling is compiled in only when MULT_BUS_TIMEOUT_EN is defined.
package mult_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    WR_B,
    WR_INIT1,
    POLL_RD,
    POLL_CHK,
    RES_RD,
    RES_CAP,
    WR_INIT0
  } state_t;

  localparam logic [4:0] REG_A    = 5'h04;
  localparam logic [4:0] REG_B    = 5'h08;
  localparam logic [4:0] REG_INIT = 5'h0C;
  localparam logic [4:0] REG_RES  = 5'h10;
  localparam logic [4:0] REG_DONE = 5'h14;

  localparam logic [15:0] INIT_SET = 16'h0001;
  localparam logic [15:0] INIT_CLR = 16'h0000;

  localparam int POLL_MAX_DEF = 255;

endpackage

// File: rtl/mult_bus_poll_cnt.sv
// Done-poll counter; hit flags the increment that reaches POLL_MAX.
// Instantiated only when MULT_BUS_TIMEOUT_EN is defined.
module mult_bus_poll_cnt #(
  parameter int POLL_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [15:0] LAST = 16'(POLL_MAX - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign hit = inc && (cnt == LAST);

endmodule

// File: rtl/mult_bus_master.sv
// Runs one multiply transaction on the peripheral bus per accepted start.
// Define MULT_BUS_TIMEOUT_EN to bound done polling by POLL_MAX.
module mult_bus_master
  import mult_bus_pkg::*;
#(
  parameter logic [4:0] ADDR_A    = REG_A,
  parameter logic [4:0] ADDR_B    = REG_B,
  parameter logic [4:0] ADDR_INIT = REG_INIT,
  parameter logic [4:0] ADDR_RES  = REG_RES,
  parameter logic [4:0] ADDR_DONE = REG_DONE,
  parameter int         POLL_MAX  = POLL_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result,
  output logic        timeout_err,
  output logic        cs,
  output logic [4:0]  addr,
  output logic        rd,
  output logic        wr,
  output logic [15:0] d_out,
  input  logic [31:0] d_in
);

  if (POLL_MAX < 1 || POLL_MAX > 65535) begin : g_bad_poll_max
    $error("mult_bus_master: POLL_MAX out of range");
  end

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        done;

  assign done = d_in[0];

`ifdef MULT_BUS_TIMEOUT_EN
  logic poll_clr;
  logic poll_inc;
  logic poll_hit;
  logic timed_out;

  assign poll_clr = (state == IDLE) && start;
  assign poll_inc = (state == POLL_CHK) && !done;

  mult_bus_poll_cnt #(
    .POLL_MAX(POLL_MAX)
  ) u_poll_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (poll_clr),
    .inc  (poll_inc),
    .hit  (poll_hit)
  );
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
`ifdef MULT_BUS_TIMEOUT_EN
      timed_out   <= 1'b0;
      timeout_err <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= op_a;
            b_q   <= op_b;
            busy  <= 1'b1;
            state <= WR_A;
`ifdef MULT_BUS_TIMEOUT_EN
            timed_out   <= 1'b0;
            timeout_err <= 1'b0;
`endif
          end
        end
        WR_A:     state <= WR_B;
        WR_B:     state <= WR_INIT1;
        WR_INIT1: state <= POLL_RD;
        POLL_RD:  state <= POLL_CHK;
        // d_in here is the reply to the strobe of the previous cycle
        POLL_CHK: begin
          if (done) begin
            state <= RES_RD;
          end
`ifdef MULT_BUS_TIMEOUT_EN
          else if (poll_hit) begin
            result    <= '0;
            timed_out <= 1'b1;
            state     <= WR_INIT0;
          end
`endif
          else begin
            state <= POLL_RD;
          end
        end
        RES_RD: state <= RES_CAP;
        RES_CAP: begin
          result <= d_in;
          state  <= WR_INIT0;
        end
        WR_INIT0: begin
          busy  <= 1'b0;
          valid <= 1'b1;
          state <= IDLE;
`ifdef MULT_BUS_TIMEOUT_EN
          timeout_err <= timed_out;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cs    = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    d_out = '0;
    unique case (state)
      WR_A: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_A;
        d_out = a_q;
      end
      WR_B: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_B;
        d_out = b_q;
      end
      WR_INIT1: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_INIT;
        d_out = INIT_SET;
      end
      POLL_RD: begin
        cs   = 1'b1;
        rd   = 1'b1;
        addr = ADDR_DONE;
      end
      RES_RD: begin
        cs   = 1'b1;
        rd   = 1'b1;
        addr = ADDR_RES;
      end
      WR_INIT0: begin
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_INIT;
        d_out = INIT_CLR;
      end
      default: ;
    endcase
  end

endmodule
